// File: rtl/gb_mbc_pkg.sv
// Shared definitions for the MBC bank controller: register region codes,
// the default RAM enable key and the bank-state bundle.
package gb_mbc_pkg;

  localparam logic [1:0] REG_RAMEN = 2'b00;
  localparam logic [1:0] REG_LO    = 2'b01;
  localparam logic [1:0] REG_HI    = 2'b10;
  localparam logic [1:0] REG_MODE  = 2'b11;

  localparam logic [3:0] RAM_EN_KEY_DEF = 4'hA;

  localparam int LO_MAX_W = 8;
  localparam int HI_MAX_W = 4;

  // Fields are sized for the widest legal configuration; narrower
  // builds keep the unused upper bits at zero.
  typedef struct packed {
    logic                ram_en;
    logic [LO_MAX_W-1:0] lo;
    logic [HI_MAX_W-1:0] hi;
    logic                mode;
  } bank_t;

endpackage

// File: rtl/gb_mbc_wr_capture.sv
// CPU write capture: samples A15..A13 and D while wr_n is low and raises
// commit on the clock where the strobe is seen released.
// Ports: ck, nres, a_hi[2:0], d[7:0], wr_n in; cap_a, cap_d, commit out.
module gb_mbc_wr_capture (
  input  logic       ck,
  input  logic       nres,
  input  logic [2:0] a_hi,
  input  logic [7:0] d,
  input  logic       wr_n,
  output logic [2:0] cap_a,
  output logic [7:0] cap_d,
  output logic       commit
);

  logic wr_q;

  always_ff @(posedge ck or negedge nres) begin
    if (!nres) begin
      wr_q  <= 1'b1;
      cap_a <= '0;
      cap_d <= '0;
    end else begin
      wr_q <= wr_n;
      if (!wr_n) begin
        cap_a <= a_hi;
        cap_d <= d;
      end
    end
  end

  // Release edge: low on the previous sample, high now.
  assign commit = ~wr_q & wr_n;

endmodule

// File: rtl/gb_mbc_bank_ctrl.sv
// MBC1-style bank controller: register file written by CPU writes to
// 0x0000-0x7FFF, plus ROM/SRAM high address and chip-select decode.
// Ports: ck, nres, a_hi, d, wr_n, rd_n, cs_n in;
//   rom_a_hi, ram_a_hi, rom_cs_n, ram_cs_n out.
// Build option: GB_MBC_MULTICART_EN selects multicart ROM wiring.
module gb_mbc_bank_ctrl
  import gb_mbc_pkg::*;
#(
  parameter int         ROM_LO_W   = 5,
  parameter int         HI_W       = 2,
  parameter logic [3:0] RAM_EN_KEY = RAM_EN_KEY_DEF
) (
  input  logic                     ck,
  input  logic                     nres,
  input  logic [2:0]               a_hi,
  input  logic [7:0]               d,
  input  logic                     wr_n,
  input  logic                     rd_n,
  input  logic                     cs_n,
  output logic [ROM_LO_W+HI_W-1:0] rom_a_hi,
  output logic [HI_W-1:0]          ram_a_hi,
  output logic                     rom_cs_n,
  output logic                     ram_cs_n
);

  localparam int W  = ROM_LO_W + HI_W;
  localparam int WW = LO_MAX_W + HI_MAX_W;

  logic [2:0] cap_a;
  logic [7:0] cap_d;
  logic       commit;
  bank_t      bank;

  gb_mbc_wr_capture u_cap (
    .ck     (ck),
    .nres   (nres),
    .a_hi   (a_hi),
    .d      (d),
    .wr_n   (wr_n),
    .cap_a  (cap_a),
    .cap_d  (cap_d),
    .commit (commit)
  );

  // Region is A14:A13 of the captured address; A15 writes are ignored.
  always_ff @(posedge ck or negedge nres) begin
    if (!nres) begin
      bank <= '0;
    end else if (commit && !cap_a[2]) begin
      unique case (cap_a[1:0])
        REG_RAMEN: bank.ram_en <= (cap_d[3:0] == RAM_EN_KEY);
        REG_LO:    bank.lo     <= LO_MAX_W'(cap_d[ROM_LO_W-1:0]);
        REG_HI:    bank.hi     <= HI_MAX_W'(cap_d[HI_W-1:0]);
        REG_MODE:  bank.mode   <= cap_d[0];
        default:   ;
      endcase
    end
  end

`ifdef GB_MBC_MULTICART_EN
  localparam int LO_SH = 4;
  logic [LO_MAX_W-1:0] lo_sel;
  assign lo_sel = {4'b0, bank.lo[3:0]};
`else
  localparam int LO_SH = ROM_LO_W;
  logic [LO_MAX_W-1:0] lo_sel;
  assign lo_sel = bank.lo;
`endif

  logic [LO_MAX_W-1:0] lo_eff;
  logic [LO_MAX_W-1:0] lo_out;
  logic [HI_MAX_W-1:0] hi_sel;
  logic [WW-1:0]       wide;
  logic                unused_bits;

  // Bank 0 in the switchable window maps to bank 1.
  assign lo_eff = (lo_sel == '0) ? LO_MAX_W'(1) : lo_sel;
  assign lo_out = a_hi[1] ? lo_eff : '0;
  assign hi_sel = (a_hi[1] | bank.mode) ? bank.hi : '0;
  assign wide   = (WW'(hi_sel) << LO_SH) | WW'(lo_out);

  assign rom_a_hi = wide[W-1:0];
  assign ram_a_hi = bank.mode ? bank.hi[HI_W-1:0] : '0;
  assign rom_cs_n = rd_n | a_hi[2];
  assign ram_cs_n = ~(bank.ram_en & ~cs_n
                      & (a_hi[2:1] == 2'b01));

  assign unused_bits = ^{wide, bank.lo, bank.hi};

endmodule
